// File: rtl/brew_sequencer.sv
`timescale 1ns/1ps
// brew_sequencer: top-level brew controller. Runs the sensor check, then
// sequences heater and pump through heat, brew and drip for the latched cup
// size. Outputs are registered from the next state, so they line up with the
// state they describe.
module brew_sequencer #(
    parameter int CNT_W             = 16,
    parameter int CHECK_TIMEOUT_CYC = 1000,
    parameter int HEAT_MAX_CYC      = 5000,
    parameter int BREW_SMALL_CYC    = 100,
    parameter int BREW_MED_CYC      = 150,
    parameter int BREW_LARGE_CYC    = 200,
    parameter int DRIP_CYC          = 50
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       CANCEL,
    input  logic [1:0] SIZE,
    input  logic [1:0] CHECK_STATUS,
    input  logic       HEATER_READY,
    output logic       CHECK_TIMEOUT,
    output logic       CHECK_EN,
    output logic       HEATER_ON,
    output logic       PUMP_ON,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAULT,
    output logic [3:0] STATE_CODE
);

    // State encoding doubles as the display code.
    typedef enum logic [3:0] {
        S_IDLE     = 4'h0,
        S_CHECK    = 4'h1,
        S_WAIT_FIX = 4'h2,
        S_HEAT     = 4'h3,
        S_BREW     = 4'h4,
        S_DRIP     = 4'h5,
        S_DONE     = 4'h6,
        S_FAULT    = 4'hF
    } state_t;

    // Counter values on the last cycle of each timed phase.
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(CHECK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] HEAT_LAST  = CNT_W'(HEAT_MAX_CYC - 1);
    localparam logic [CNT_W-1:0] SMALL_LAST = CNT_W'(BREW_SMALL_CYC - 1);
    localparam logic [CNT_W-1:0] MED_LAST   = CNT_W'(BREW_MED_CYC - 1);
    localparam logic [CNT_W-1:0] LARGE_LAST = CNT_W'(BREW_LARGE_CYC - 1);
    localparam logic [CNT_W-1:0] DRIP_LAST  = CNT_W'(DRIP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] brew_last;
    logic [1:0]       size_q;
    logic             start_q;
    logic             start_edge;

    assign start_edge = START & ~start_q;

    // Pump duration for the cup size latched at START.
    always_comb begin
        case (size_q)
            2'b00:   brew_last = SMALL_LAST;
            2'b01:   brew_last = MED_LAST;
            default: brew_last = LARGE_LAST;
        endcase
    end

    // Next-state logic; CANCEL outranks everything except a sensor fault.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:
                if (start_edge && (SIZE != 2'b11)) state_d = S_CHECK;
            S_CHECK:
                if (CHECK_STATUS == 2'b11)      state_d = S_FAULT;
                else if (CANCEL)                state_d = S_IDLE;
                else if (CHECK_STATUS == 2'b10) state_d = S_HEAT;
                else if (CHECK_STATUS == 2'b01) state_d = S_WAIT_FIX;
            S_WAIT_FIX:
                if (CHECK_STATUS == 2'b11)      state_d = S_FAULT;
                else if (CANCEL)                state_d = S_IDLE;
                else if (CHECK_STATUS == 2'b10) state_d = S_HEAT;
            S_HEAT:
                if (CANCEL)                     state_d = S_IDLE;
                else if (HEATER_READY)          state_d = S_BREW;
                else if (cnt_q == HEAT_LAST)    state_d = S_FAULT;
            S_BREW:
                if (CANCEL || (cnt_q == brew_last)) state_d = S_DRIP;
            S_DRIP:
                if (cnt_q == DRIP_LAST)         state_d = S_DONE;
            S_DONE:
                state_d = S_IDLE;
            S_FAULT:
                state_d = S_FAULT;
            default:
                state_d = S_IDLE;
        endcase
    end

    // State, phase counter (cleared on transitions, saturating), size latch, START history.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            size_q  <= 2'b00;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= START;
            if (state_d != state_q)  cnt_q <= '0;
            else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            if ((state_q == S_IDLE) && (state_d == S_CHECK)) size_q <= SIZE;
        end
    end

    // Registered Moore outputs; the timeout flag stays up until WAIT_FIX is left.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CHECK_TIMEOUT <= 1'b0;
            CHECK_EN      <= 1'b0;
            HEATER_ON     <= 1'b0;
            PUMP_ON       <= 1'b0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            FAULT         <= 1'b0;
            STATE_CODE    <= 4'h0;
        end else begin
            CHECK_TIMEOUT <= (state_q == S_WAIT_FIX) && (state_d == S_WAIT_FIX) &&
                             (cnt_q >= TMO_LAST);
            CHECK_EN      <= (state_d == S_CHECK) || (state_d == S_WAIT_FIX);
            HEATER_ON     <= (state_d == S_HEAT) || (state_d == S_BREW);
            PUMP_ON       <= (state_d == S_BREW);
            BUSY          <= (state_d != S_IDLE) && (state_d != S_FAULT);
            DONE          <= (state_d == S_DONE);
            FAULT         <= (state_d == S_FAULT);
            STATE_CODE    <= state_d;
        end
    end

endmodule

// File: tb/tb_brew_sequencer.sv
`timescale 1ns/1ps
// Bench for brew_sequencer: each brew is described by a few random scenario
// knobs; the expected per-brew summary (states visited, phase lengths, done
// pulses, end state) is computed arithmetically and queued. A monitor
// summarises what the DUT actually did and compares per brew.
module tb_brew_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       START = 1'b0;
    logic       CANCEL = 1'b0;
    logic [1:0] SIZE = 2'b00;
    logic [1:0] CHECK_STATUS = 2'b00;
    logic       HEATER_READY = 1'b0;
    logic       CHECK_TIMEOUT, CHECK_EN, HEATER_ON, PUMP_ON, BUSY, DONE, FAULT;
    logic [3:0] STATE_CODE;

    brew_sequencer dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .CANCEL(CANCEL), .SIZE(SIZE),
        .CHECK_STATUS(CHECK_STATUS), .HEATER_READY(HEATER_READY),
        .CHECK_TIMEOUT(CHECK_TIMEOUT), .CHECK_EN(CHECK_EN), .HEATER_ON(HEATER_ON),
        .PUMP_ON(PUMP_ON), .BUSY(BUSY), .DONE(DONE), .FAULT(FAULT),
        .STATE_CODE(STATE_CODE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] path;
        int          chk, tmo, heat, pump, drip, done;
        logic [3:0]  endc;
    } rec_t;

    rec_t expq[$];
    int   errs = 0;
    int   checks = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Output pattern the spec assigns to each display code:
    // {CHECK_EN, HEATER_ON, PUMP_ON, BUSY, DONE, FAULT}
    function automatic logic [5:0] decode(input logic [3:0] c);
        case (c)
            4'h0:       return 6'b000000;
            4'h1, 4'h2: return 6'b100100;
            4'h3:       return 6'b010100;
            4'h4:       return 6'b011100;
            4'h5:       return 6'b000100;
            4'h6:       return 6'b000110;
            4'hF:       return 6'b000001;
            default:    return 6'b111111;
        endcase
    endfunction

    // Monitor: per-cycle output sanity, plus a per-brew summary popped against the queue.
    initial begin
        logic [31:0] path;
        logic [3:0]  last;
        int          c_chk, c_tmo, c_heat, c_pump, c_drip, c_done;
        bit          in_txn;
        rec_t        e;
        in_txn = 0; path = 0; last = 0;
        c_chk = 0; c_tmo = 0; c_heat = 0; c_pump = 0; c_drip = 0; c_done = 0;
        forever begin
            @(negedge CLK);
            cmp("out_decode", 32'({CHECK_EN, HEATER_ON, PUMP_ON, BUSY, DONE, FAULT}),
                32'(decode(STATE_CODE)));
            cmp("timeout_outside_waitfix", 32'(CHECK_TIMEOUT && (STATE_CODE != 4'h2)), 32'd0);
            if (!in_txn && BUSY) begin
                in_txn = 1; path = 0; last = 0;
                c_chk = 0; c_tmo = 0; c_heat = 0; c_pump = 0; c_drip = 0; c_done = 0;
            end
            if (in_txn) begin
                if ((STATE_CODE != last) && (STATE_CODE != 4'h0)) path = {path[27:0], STATE_CODE};
                last = STATE_CODE;
                c_chk  += int'(CHECK_EN);
                c_tmo  += int'(CHECK_TIMEOUT);
                c_heat += int'(HEATER_ON && !PUMP_ON);
                c_pump += int'(PUMP_ON);
                c_drip += int'(STATE_CODE == 4'h5);
                c_done += int'(DONE);
                if ((STATE_CODE == 4'h0) || (STATE_CODE == 4'hF)) begin
                    in_txn = 0;
                    if (expq.size() == 0) begin
                        checks++; errs++;
                        $display("FAIL unexpected_brew: got path %h expected none", path);
                    end else begin
                        e = expq.pop_front();
                        cmp("path",        path,         e.path);
                        cmp("check_cyc",   32'(c_chk),   32'(e.chk));
                        cmp("timeout_cyc", 32'(c_tmo),   32'(e.tmo));
                        cmp("heat_cyc",    32'(c_heat),  32'(e.heat));
                        cmp("pump_cyc",    32'(c_pump),  32'(e.pump));
                        cmp("drip_cyc",    32'(c_drip),  32'(e.drip));
                        cmp("done_pulses", 32'(c_done),  32'(e.done));
                        cmp("end_code",    32'(STATE_CODE), 32'(e.endc));
                    end
                end
            end
        end
    end

    task automatic idle_gap();
        START = 1'b0; SIZE = 2'b00; CHECK_STATUS = 2'b00; HEATER_READY = 1'b0;
        repeat (2 + $urandom % 3) begin
            CANCEL = 1'($urandom % 2);
            tick();
        end
        CANCEL = 1'b0;
    endtask

    // From FAULT: START edges are ignored, reset clears everything.
    task automatic fault_exit();
        START = 1'b0; CANCEL = 1'b0; tick(); tick();
        START = 1'b1; tick(); START = 1'b0; tick(); START = 1'b1; tick();
        cmp("fault_sticky", 32'(FAULT), 32'd1);
        cmp("fault_code", 32'(STATE_CODE), 32'hF);
        START = 1'b0;
        #1 RST_N = 1'b0;
        #1 cmp("fault_reset_outs", 32'({CHECK_TIMEOUT, CHECK_EN, HEATER_ON, PUMP_ON, BUSY,
                                         DONE, FAULT, STATE_CODE}), 32'd0);
        tick();
        RST_N = 1'b1;
        idle_gap();
    endtask

    // Scenario: a cycles of 00, f cycles of 01, then fin; heater ready on HEAT
    // cycle h; optional cancel at end of check, at HEAT cycle ch, or in BREW
    // (bmode 1: cancel at BREW cycle cb, bmode 2: reset during BREW cycle cb).
    task automatic run_txn(input int sz, input int a, input int f, input logic [1:0] fin,
                           input bit cxl_chk, input bit heatfault, input int h,
                           input bit cxl_heat, input int ch, input int bmode, input int cb);
        rec_t e;
        int   len, n;
        len = (sz == 0) ? 100 : (sz == 1) ? 150 : 200;
        e.path = 32'h1; e.chk = a + f + 1; e.tmo = (f > 1000) ? f - 1000 : 0;
        e.heat = 0; e.pump = 0; e.drip = 0; e.done = 0; e.endc = 4'h0;
        if (f > 0) e.path = {e.path[27:0], 4'h2};
        if (fin == 2'b11) begin
            e.path = {e.path[27:0], 4'hF}; e.endc = 4'hF;
        end else if (!cxl_chk) begin
            e.path = {e.path[27:0], 4'h3};
            if (heatfault) begin
                e.heat = 5000; e.path = {e.path[27:0], 4'hF}; e.endc = 4'hF;
            end else if (cxl_heat && ch <= h) begin
                e.heat = ch + 1;
            end else begin
                e.heat = h + 1; e.path = {e.path[27:0], 4'h4};
                if (bmode == 2) e.pump = cb;
                else begin
                    e.pump = (bmode == 1) ? cb + 1 : len;
                    e.path = {e.path[23:0], 8'h56}; e.drip = 50; e.done = 1;
                end
            end
        end
        expq.push_back(e);

        SIZE = 2'(sz); START = 1'b1; tick();
        for (int k = 0; k <= a + f; k++) begin
            CHECK_STATUS = (k < a) ? 2'b00 : (k < a + f) ? 2'b01 : fin;
            CANCEL = cxl_chk && (k == a + f);
            START = 1'($urandom % 2); SIZE = 2'($urandom);
            tick();
        end
        CANCEL = 1'b0; CHECK_STATUS = 2'b00;
        if (fin == 2'b11) begin fault_exit(); return; end
        if (cxl_chk) begin idle_gap(); return; end

        if (heatfault) begin
            repeat (5000) tick();
            fault_exit(); return;
        end
        n = (cxl_heat && ch <= h) ? ch : h;
        for (int j = 0; j <= n; j++) begin
            HEATER_READY = (j == h);
            CANCEL = cxl_heat && (j == ch);
            START = 1'($urandom % 2); SIZE = 2'($urandom);
            tick();
        end
        HEATER_READY = 1'b0; CANCEL = 1'b0;
        if (cxl_heat && ch <= h) begin idle_gap(); return; end

        if (bmode == 2) begin
            for (int k = 0; k < cb; k++) begin
                START = 1'($urandom % 2); SIZE = 2'($urandom); tick();
            end
            #1 RST_N = 1'b0;
            #1;
            cmp("rst_async_pump", 32'(PUMP_ON), 32'd0);
            cmp("rst_async_heater", 32'(HEATER_ON), 32'd0);
            cmp("rst_async_busy", 32'(BUSY), 32'd0);
            cmp("rst_async_code", 32'(STATE_CODE), 32'd0);
            START = 1'b0;
            tick(); tick();
            RST_N = 1'b1;
            idle_gap(); return;
        end
        n = (bmode == 1) ? cb + 1 : len;
        for (int k = 0; k < n; k++) begin
            CANCEL = (bmode == 1) && (k == cb);
            START = 1'($urandom % 2); SIZE = 2'($urandom);
            tick();
        end
        for (int k = 0; k <= 50; k++) begin    // 50 drip cycles + DONE_ST
            CANCEL = 1'($urandom % 2);
            START = 1'($urandom % 2); SIZE = 2'($urandom);
            tick();
        end
        idle_gap();
    endtask

    initial begin
        int m, bm;
        #2 RST_N = 1'b0;
        tick(); tick();
        cmp("reset_outs", 32'({CHECK_TIMEOUT, CHECK_EN, HEATER_ON, PUMP_ON, BUSY, DONE,
                               FAULT, STATE_CODE}), 32'd0);
        RST_N = 1'b1;
        tick(); tick();

        run_txn(1, 2, 0,    2'b10, 0, 0, 20,   0, 0, 0, 0);   // happy path, medium
        run_txn(0, 1, 300,  2'b10, 0, 0, 5,    0, 0, 0, 0);   // correctable error
        run_txn(2, 0, 1001, 2'b11, 0, 0, 0,    0, 0, 0, 0);   // timeout then sensor fault
        run_txn(0, 0, 1000, 2'b10, 0, 0, 3,    0, 0, 0, 0);   // fixed just before timeout
        run_txn(1, 0, 0,    2'b10, 0, 1, 0,    0, 0, 0, 0);   // heater fault
        run_txn(2, 0, 0,    2'b10, 0, 0, 3,    0, 0, 1, 40);  // cancel in BREW
        run_txn(0, 0, 0,    2'b10, 0, 0, 10,   1, 5, 0, 0);   // cancel in HEAT
        run_txn(0, 0, 0,    2'b10, 0, 0, 4999, 0, 0, 0, 0);   // ready on heat limit cycle
        run_txn(1, 0, 2,    2'b11, 1, 0, 0,    0, 0, 0, 0);   // cancel + status 11 -> FAULT
        run_txn(1, 1, 0,    2'b10, 1, 0, 0,    0, 0, 0, 0);   // cancel beats status 10
        run_txn(1, 1, 0,    2'b10, 0, 0, 2,    0, 0, 2, 30);  // reset mid-BREW

        // invalid size is ignored
        SIZE = 2'b11; START = 1'b1; tick(); tick(); START = 1'b0; tick();
        cmp("invalid_size_busy", 32'(BUSY), 32'd0);
        cmp("invalid_size_code", 32'(STATE_CODE), 32'd0);
        idle_gap();

        for (int r = 0; r < 20; r++) begin
            m = int'($urandom % 8);
            bm = (m == 0) ? 2 : (m < 3) ? 1 : 0;
            run_txn(int'($urandom % 3), int'($urandom % 4),
                    ($urandom % 2 == 0) ? int'($urandom_range(1, 40)) : 0,
                    ($urandom % 8 == 0) ? 2'b11 : 2'b10,
                    ($urandom % 10 == 0), 0, int'($urandom % 30),
                    ($urandom % 5 == 0), int'($urandom % 30),
                    bm, 1 + int'($urandom % 99));
        end

        repeat (5) tick();
        cmp("queue_drained", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
